memory_dp: RTL
==============

# memory_dp

Parametrised dual-port word memory for the CPU's instruction and data stores. Port A is a read-only fetch port; port B is a read/write data port with byte-lane enables. After reset, a built-in init sequencer clears the array one word per cycle and raises `ready`, so no file loading happens inside the block. The memory sits between the fetch/memory stages and any host preload logic, which writes through port B once `ready` is high.

## Interface
- `ASIZE`, 16: address width, both ports.
- `DSIZE`, 16: data width; multiple of 8.
- `DEPTH`, 1024: implemented words; 1 ≤ DEPTH ≤ 2**ASIZE.
- `RDW_MODE`, 0: read-during-write to the same address. 0 = read-first (old data). 1 = write-first (new data).
- `INIT_VAL`, 0: word written to every location by the init sweep.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `addr_a` input ASIZE: port A read address.
- `dout_a` output DSIZE: port A registered read data.
- `wen_b` input 1: port B write enable, active-low.
- `ben_b` input DSIZE/8: port B byte enables, active-high; bit i covers data bits [8i+7:8i].
- `addr_b` input ASIZE: port B address.
- `din_b` input DSIZE: port B write data.
- `dout_b` output DSIZE: port B registered read data.
- `ready` output 1: init sweep done; accesses are accepted.
- `oob_err` output 1: sticky flag set by any out-of-range access.

## Operation
- FSM states: INIT, READY.
- While `rst` is high:
  - state = INIT; sweep pointer = 0.
  - `ready`, `oob_err`, `dout_a` and `dout_b` all = 0.
  - The array contents are not touched.
- INIT:
  - Each cycle writes INIT_VAL to `mem[ptr]`, then increments `ptr`.
  - When `ptr` = DEPTH-1 is written, the next state is READY.
  - Port inputs are ignored. `dout_a` and `dout_b` stay 0. `oob_err` is not updated.
- READY:
  - Port A: `dout_a` <= `mem[addr_a]` every cycle.
  - Port B read: `dout_b` <= `mem[addr_b]` every cycle, whether or not a write happens.
  - Port B write: when `wen_b`=0, each byte lane i with `ben_b[i]`=1 is written from `din_b`. Other lanes keep their old value.
  - `wen_b`=0 with `ben_b`=0 is a no-op write.
- Read-during-write, same cycle and same address (applies to both ports):
  - RDW_MODE=0: dout returns the pre-write word.
  - RDW_MODE=1: dout returns the merged post-write word (enabled lanes new, others old).
- Out of range (address ≥ DEPTH):
  - Read: dout <= 0.
  - Write: dropped; no wrap or alias.
  - Either sets `oob_err`. It clears only on `rst`.
- Reset mid-sweep or mid-operation restarts INIT from address 0.

## Timing
- Init takes exactly DEPTH cycles after `rst` falls. `ready` rises on the edge that completes the last clear write.
- Read latency is 1 cycle: the address presented at edge N gives data valid after edge N.
- A write at edge N is visible to reads issued at edge N+1 on either port.
- `oob_err` asserts on the edge that samples the offending address.
- `ready` stays high until the next `rst`.

## Test plan
- Init: DEPTH=1024, INIT_VAL=16'hA5A5, pre-poison the array, release `rst` → `ready` stays 0 for exactly 1024 cycles. After `ready`, reads at 0, 511 and 1023 on both ports return A5A5.
- Byte lanes: write 16'h1234 to 0x010 with `ben_b`=2'b11, then 16'hAB00 with `ben_b`=2'b10 → port A reads 0x010 = 16'hAB34 one cycle later.
- Read-during-write: `mem[0x20]`=16'h1111. Write 16'h2222 to 0x20 while `addr_a`=0x20 → RDW_MODE=0 gives `dout_a`=`dout_b`=1111. RDW_MODE=1 gives 2222.
- Out of range: DEPTH=1024, write 16'hFFFF to 0x0400 → `oob_err`=1 and `dout_b`=0. `mem[0x000]` is unchanged (no alias). `oob_err` stays 1 until `rst`.
- Ignored during init: `wen_b`=0 to 0x005 with data 16'hDEAD during INIT → after `ready`, 0x005 reads INIT_VAL.
- Reset mid-sweep: assert `rst` at cycle 300 of init, then release → `ready` rises exactly 1024 cycles after the release. All outputs are 0 while `rst` is high.

Source files
------------

// File: rtl/memory_dp.sv
// Dual-port word memory: port A read-only fetch, port B byte-lane read/write.
// After reset an init sweep writes INIT_VAL to every word before ready rises.
module memory_dp #(
    parameter int                 ASIZE    = 16,
    parameter int                 DSIZE    = 16,
    parameter int                 DEPTH    = 1024,
    parameter int                 RDW_MODE = 0,
    parameter logic [DSIZE-1:0]   INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ASIZE-1:0]   addr_a,
    output logic [DSIZE-1:0]   dout_a,
    input  logic               wen_b,
    input  logic [DSIZE/8-1:0] ben_b,
    input  logic [ASIZE-1:0]   addr_b,
    input  logic [DSIZE-1:0]   din_b,
    output logic [DSIZE-1:0]   dout_b,
    output logic               ready,
    output logic               oob_err,
    output logic               dbg_state_o
);

    localparam int               IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               NLANE   = DSIZE / 8;
    localparam logic [ASIZE:0]   DEPTH_X = (ASIZE+1)'(DEPTH);

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

    logic [DSIZE-1:0] mem [DEPTH];

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic             ready_q;
    logic             oob_q;
    logic [DSIZE-1:0] dout_a_q;
    logic [DSIZE-1:0] dout_b_q;

    logic             a_in, b_in;
    logic [IW-1:0]    idx_a, idx_b;
    logic [DSIZE-1:0] old_a, old_b, merged_b;
    logic             we_b, init_we, same_addr;
    logic [DSIZE-1:0] dout_a_d, dout_b_d;

    always_comb begin
        a_in     = ({1'b0, addr_a} < DEPTH_X);
        b_in     = ({1'b0, addr_b} < DEPTH_X);
        idx_a    = addr_a[IW-1:0];
        idx_b    = addr_b[IW-1:0];
        old_a    = mem[idx_a];
        old_b    = mem[idx_b];
        merged_b = old_b;
        for (int i = 0; i < NLANE; i++) begin
            if (ben_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
        end
        // Out-of-range writes are dropped rather than aliased onto low addresses.
        we_b      = (state_q == READY) && !wen_b && b_in;
        init_we   = (state_q == INIT) && !rst;
        same_addr = we_b && a_in && (idx_a == idx_b);

        dout_a_d = '0;
        if (a_in) dout_a_d = (RDW_MODE == 1 && same_addr) ? merged_b : old_a;
        dout_b_d = '0;
        if (b_in) dout_b_d = (RDW_MODE == 1 && we_b) ? merged_b : old_b;
    end

    // Array storage carries no reset: reset only restarts the sweep.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[ptr_q] <= INIT_VAL;
        end else if (we_b) begin
            mem[idx_b] <= merged_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            oob_q    <= 1'b0;
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    dout_a_q <= '0;
                    dout_b_q <= '0;
                    if (ptr_q == IW'(DEPTH - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + IW'(1);
                    end
                end
                READY: begin
                    dout_a_q <= dout_a_d;
                    dout_b_q <= dout_b_d;
                    if (!a_in || !b_in) oob_q <= 1'b1;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;
    assign ready       = ready_q;
    assign oob_err     = oob_q;
    assign dbg_state_o = state_q;

endmodule
